// File: rtl/n4_timer_ctrl.sv
// n4_timer_ctrl: prescaled 4-bit terminal-count timer with one-shot and
// periodic modes, sticky done/overrun flags.
module n4_timer_ctrl #(
    parameter int unsigned DIV = 1
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [3:0] tc,
    input  logic       ack,
    output logic       ei,
    output logic [3:0] q3_q0,
    output logic       eu,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] PMAX = 4'(DIV - 1);

    state_e     state_q, state_d;
    logic [3:0] psc_q, psc_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] tc_q, tc_d;
    logic       mode_q, mode_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;
    logic       hit;

    // stop in the same cycle as a terminal step wins over the expiry
    always_comb begin
        busy = (state_q == RUN);
        ei   = busy && (psc_q == PMAX);
        hit  = ei && (cnt_q == tc_q) && !stop;
        eu   = hit;
    end

    assign q3_q0 = cnt_q;
    assign done  = done_q;
    assign ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
        mode_d  = mode_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (ack) begin
            done_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    tc_d    = tc;
                    mode_d  = mode;
                    cnt_d   = 4'd0;
                    psc_d   = 4'd0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    psc_d   = 4'd0;
                end else begin
                    psc_d = (psc_q == PMAX) ? 4'd0 : psc_q + 4'd1;
                    if (hit) begin
                        cnt_d  = 4'd0;
                        done_d = 1'b1;
                        if (!mode_q) begin
                            state_d = DONE;
                        end else if (done_q && !ack) begin
                            ovf_d = 1'b1;
                        end
                    end else if (ei) begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    tc_d    = tc;
                    mode_d  = mode;
                    cnt_d   = 4'd0;
                    psc_d   = 4'd0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b0;
                end else if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            state_q <= IDLE;
            psc_q   <= 4'd0;
            cnt_q   <= 4'd0;
            tc_q    <= 4'd0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_n4_timer_ctrl.sv
// Bench for n4_timer_ctrl: DIV=1 and DIV=4 instances share stimulus;
// expected output vectors are queued per cycle and checked at negedge.
module tb_n4_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset_ = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] tc = 4'd0;
    logic       ack = 1'b0;

    logic       ei1, eu1, busy1, done1, ovf1;
    logic [3:0] q1;
    logic       ei4, eu4, busy4, done4, ovf4;
    logic [3:0] q4;

    logic [8:0] sb[$];
    logic [8:0] e;
    int compared = 0;
    int mismatched = 0;

    wire [8:0] obs1 = {q1, ei1, eu1, busy1, done1, ovf1};
    wire [8:0] obs4 = {q4, ei4, eu4, busy4, done4, ovf4};

    always #5 clock = ~clock;

    n4_timer_ctrl #(.DIV(1)) u_div1 (
        .clock(clock), .reset_(reset_), .start(start), .stop(stop),
        .mode(mode), .tc(tc), .ack(ack), .ei(ei1), .q3_q0(q1),
        .eu(eu1), .busy(busy1), .done(done1), .ovf(ovf1)
    );

    n4_timer_ctrl #(.DIV(4)) u_div4 (
        .clock(clock), .reset_(reset_), .start(start), .stop(stop),
        .mode(mode), .tc(tc), .ack(ack), .ei(ei4), .q3_q0(q4),
        .eu(eu4), .busy(busy4), .done(done4), .ovf(ovf4)
    );

    // packed as {q3_q0, ei, eu, busy, done, ovf}
    function automatic logic [8:0] ev(int q, bit xei, bit xeu,
                                      bit xbusy, bit xdone, bit xovf);
        return {4'(q), xei, xeu, xbusy, xdone, xovf};
    endfunction

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; mode = 1'b0; tc = 4'd0; ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_ = 1'b1;
        @(posedge clock); #1;
        reset_ = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_ = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_ = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(ev(0, 0, 0, 0, 0, 0));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (k == 0 && obs1 !== e) begin
                mismatched++;
                $display("FAIL reset_div1 got %b want %b", obs1, e);
            end
            if (k == 1 && obs4 !== e) begin
                mismatched++;
                $display("FAIL reset_div4 got %b want %b", obs4, e);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_oneshot();
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            start = (k == 0); mode = 1'b0; tc = 4'd3;
            stop = (k == 5); ack = (k == 7);
            if (k == 0) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else if (k <= 4) sb.push_back(ev(k - 1, 1, k == 4, 1, 0, 0));
            else if (k <= 7) sb.push_back(ev(0, 0, 0, 0, 1, 0));
            else sb.push_back(ev(0, 0, 0, 0, 0, 0));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs1 !== e) begin
                mismatched++;
                $display("FAIL oneshot k=%0d got %b want %b", k, obs1, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_periodic_div4();
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            start = (k == 0) || (k == 23); mode = 1'b1; tc = 4'd1;
            ack = (k == 19); stop = (k == 22);
            if (k == 0) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else if (k <= 22)
                sb.push_back(ev(((k - 1) / 4) % 2, (k % 4) == 0,
                                (k % 8) == 0, 1, k >= 9 && k <= 19, k >= 17));
            else if (k == 23) sb.push_back(ev(0, 0, 0, 0, 0, 1));
            else sb.push_back(ev(0, 0, 0, 1, 0, 0));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs4 !== e) begin
                mismatched++;
                $display("FAIL periodic_div4 k=%0d got %b want %b", k, obs4, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_tc0_ack();
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            start = (k == 0); mode = 1'b1; tc = 4'd0;
            ack = (k >= 2 && k <= 4); stop = (k == 6 || k == 7);
            if (k == 0) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else if (k == 1) sb.push_back(ev(0, 1, 1, 1, 0, 0));
            else if (k <= 5) sb.push_back(ev(0, 1, 1, 1, 1, 0));
            else if (k == 6) sb.push_back(ev(0, 1, 0, 1, 1, 1));
            else sb.push_back(ev(0, 0, 0, 0, 1, 1));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs1 !== e) begin
                mismatched++;
                $display("FAIL tc0_ack k=%0d got %b want %b", k, obs1, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_tc15();
        do_reset();
        for (int k = 0; k <= 18; k++) begin
            start = (k == 0); mode = 1'b1; tc = 4'd15;
            if (k == 0) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else if (k <= 16) sb.push_back(ev(k - 1, 1, k == 16, 1, 0, 0));
            else sb.push_back(ev(k - 17, 1, 0, 1, 1, 0));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs1 !== e) begin
                mismatched++;
                $display("FAIL tc15 k=%0d got %b want %b", k, obs1, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_stop_at_expiry();
        do_reset();
        for (int k = 0; k <= 4; k++) begin
            start = (k == 0); mode = 1'b0; tc = 4'd2; stop = (k == 3);
            if (k == 0 || k == 4) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else sb.push_back(ev(k - 1, 1, 0, 1, 0, 0));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs1 !== e) begin
                mismatched++;
                $display("FAIL stop_at_expiry k=%0d got %b want %b", k, obs1, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_done_start_ack();
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            start = (k == 0 || k == 4 || k == 5);
            tc = (k == 4) ? 4'd2 : 4'd1;
            mode = (k == 5);
            ack = (k == 4 || k == 9);
            stop = 1'b0;
            case (k)
                0:       sb.push_back(ev(0, 0, 0, 0, 0, 0));
                1:       sb.push_back(ev(0, 1, 0, 1, 0, 0));
                2:       sb.push_back(ev(1, 1, 1, 1, 0, 0));
                3, 4:    sb.push_back(ev(0, 0, 0, 0, 1, 0));
                5:       sb.push_back(ev(0, 1, 0, 1, 0, 0));
                6:       sb.push_back(ev(1, 1, 0, 1, 0, 0));
                7:       sb.push_back(ev(2, 1, 1, 1, 0, 0));
                8, 9:    sb.push_back(ev(0, 0, 0, 0, 1, 0));
                default: sb.push_back(ev(0, 0, 0, 0, 0, 0));
            endcase
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs1 !== e) begin
                mismatched++;
                $display("FAIL done_start_ack k=%0d got %b want %b", k, obs1, e);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_midrun();
        int j;
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            reset_ = (k == 10);
            start = (k == 0 || k == 10 || k == 12);
            tc = (k < 12) ? 4'd0 : 4'd1;
            mode = (k < 12);
            j = k - 12;
            if (k == 0) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else if (k <= 9)
                sb.push_back(ev(0, (k % 4) == 0, (k % 4) == 0, 1, k >= 5, k >= 9));
            else if (k == 10) sb.push_back(ev(0, 0, 0, 1, 1, 1));
            else if (k <= 12) sb.push_back(ev(0, 0, 0, 0, 0, 0));
            else if (k <= 20)
                sb.push_back(ev(j > 4 ? 1 : 0, (j % 4) == 0, j == 8, 1, 0, 0));
            else sb.push_back(ev(0, 0, 0, 0, 1, 0));
            @(negedge clock);
            e = sb.pop_front();
            compared++;
            if (obs4 !== e) begin
                mismatched++;
                $display("FAIL reset_midrun k=%0d got %b want %b", k, obs4, e);
            end
            @(posedge clock); #1;
        end
        reset_ = 1'b0;
    endtask

    initial begin
        idle_inputs();
        @(posedge clock); #1;
        test_reset();
        test_oneshot();
        test_periodic_div4();
        test_tc0_ack();
        test_tc15();
        test_stop_at_expiry();
        test_done_start_ack();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/n4_timer_ctrl.md
N4_TIMER_CTRL -- requirements
Module: n4_timer_ctrl

Interface
REQ-001 SHALL have parameter: DIV, default 1, prescale ratio (legal 1..16): one count step every DIV clock cycles while running.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_  input  1  reset, synchronous and active-high (1 = reset, sampled on clock rising edge).
REQ-004 SHALL have port: start  input  1  arm/restart request.
REQ-005 SHALL have port: stop  input  1  abort request.
REQ-006 SHALL have port: mode  input  1  0 = one-shot, 1 = periodic; sampled at start.
REQ-007 SHALL have port: tc  input  4  terminal count; sampled at start.
REQ-008 SHALL have port: ack  input  1  clears done.
REQ-009 SHALL have port: ei  output  1  count-step enable (combinational from state/prescaler), high in step cycles.
REQ-010 SHALL have port: q3_q0  output  4  current count, registered.
REQ-011 SHALL have port: eu  output  1  expiry pulse = ei AND (q3_q0 == latched tc), combinational.
REQ-012 SHALL have port: busy  output  1  high in RUN.
REQ-013 SHALL have port: done  output  1  sticky expiry flag.
REQ-014 SHALL have port: ovf  output  1  sticky overrun flag.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; busy = (state == RUN).
REQ-016 SHALL, in IDLE with start=1, latch tc/mode, clear q3_q0, prescaler and ovf, go to RUN at that edge.
REQ-017 SHALL, in RUN, advance a prescaler 0..DIV-1, wrapping to 0; ei = 1 exactly in cycles where prescaler == DIV-1 (DIV=1: ei=1 every RUN cycle).
REQ-018 SHALL, on ei with q3_q0 != tc_latched, increment q3_q0 by 1 (modulo 16).
REQ-019 SHALL, on ei with q3_q0 == tc_latched (eu=1), load q3_q0 = 0 instead of incrementing; expiry period = (tc+1)*DIV cycles; tc=0 expires on every step.
REQ-020 SHALL, on expiry in one-shot mode, go to DONE and set done=1; q3_q0 = 0 in DONE.
REQ-021 SHALL, on expiry in periodic mode, stay in RUN and set done=1; if done already 1 and ack=0 in that cycle, set ovf=1.
REQ-022 SHALL clear done on ack=1; ack and expiry in the same cycle leave done=1 and do not set ovf.
REQ-023 SHALL, on stop=1 in RUN, go to IDLE, clear q3_q0 and prescaler, suppress eu/expiry in that cycle (stop beats expiry); done/ovf unchanged.
REQ-024 SHALL ignore start while in RUN (no restart; latched tc/mode unchanged).
REQ-025 SHALL, in DONE: start=1 -> RUN per REQ-016 with done cleared (start beats ack); else ack=1 -> IDLE with done cleared; else hold.
REQ-026 SHALL ignore stop in IDLE and DONE; ignore changes of tc/mode while not sampling.
REQ-027 SHALL hold ei=0, eu=0 outside RUN.

Reset
REQ-028 SHALL, when reset_=1 at a rising edge, force state=IDLE, q3_q0=0, prescaler=0, done=0, ovf=0, latched tc=0, mode=0; reset beats all other inputs.
REQ-029 SHALL, after reset mid-RUN, produce no eu/ei in the following cycle and require a new start.

Verification
REQ-030 SHALL cover: DIV=1, mode=0, tc=3, start pulse -> q3_q0 0,1,2,3, eu on 4th RUN cycle, then done=1, busy=0, q3_q0=0.
REQ-031 SHALL cover: DIV=4, mode=1, tc=1, no ack -> eu every 8 cycles; first eu sets done, second sets ovf=1; ack then clears done, ovf stays 1 until next start.
REQ-032 SHALL cover: DIV=1, tc=0, mode=1 -> eu every RUN cycle, q3_q0 stays 0; tc=15 -> q3_q0 counts 0..15, eu at 15, back to 0.
REQ-033 SHALL cover: stop asserted in the cycle where eu would fire (q3_q0=tc, ei=1) -> no eu, done unchanged, IDLE, q3_q0=0 next cycle.
REQ-034 SHALL cover: in DONE, start and ack together -> RUN, done=0, new tc latched; start during RUN with different tc -> ignored, period unchanged.
REQ-035 SHALL cover: reset_=1 mid-RUN with done=1, ovf=1 -> all outputs 0 next cycle; start after reset runs normally.
